prpg_seq_ctrl: RTL

Instruction sequencer for the 8-bit PRPG datapath. Fetches 14-bit instructions from an external program ROM, decodes them, and drives the LFSR engine's configure, seed, step and load controls. Owns the pattern-memory address register and the store/load handshakes. Sits between the program ROM, the LFSR engine and the pattern memory; it replaces the free-running combinational decode with a clocked, cycle-accurate control flow.

---
 rtl/prpg_seq_ctrl.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/prpg_seq_ctrl.sv
// prpg_seq_ctrl: instruction sequencer for the 8-bit PRPG datapath.
// Fetches 14-bit words from a combinational program ROM, decodes them and drives the
// LFSR engine (config/seed/step/load) and the pattern-memory address and strobes.
// Optional feature macro: PRPG_SEQ_RUNCNT_EN -- when defined, "run" steps opd times
// (opd == 0 counts as 1) through a RUN state; otherwise "run" always steps once.
module prpg_seq_ctrl #(
    parameter int unsigned PC_W   = 6,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [13:0]       i_instr,
    output logic [PC_W-1:0]   o_pc,
    output logic              o_tap_we,
    output logic [6:0]        o_tap,
    output logic              o_seed_we,
    output logic [7:0]        o_seed,
    output logic              o_step,
    input  logic [7:0]        i_lfsr_q,
    output logic              o_ld_we,
    output logic [7:0]        o_ld_data,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [7:0]        o_mem_wdata,
    output logic              o_mem_re,
    input  logic [7:0]        i_mem_rdata,
    output logic              o_busy,
    output logic              o_halted,
    output logic              o_err
);

    localparam logic [5:0] OpHalt    = 6'h00;
    localparam logic [5:0] OpConfig  = 6'h01;
    localparam logic [5:0] OpSeed    = 6'h02;
    localparam logic [5:0] OpRun     = 6'h03;
    localparam logic [5:0] OpInitAdr = 6'h04;
    localparam logic [5:0] OpStore   = 6'h05;
    localparam logic [5:0] OpAddAdr  = 6'h06;
    localparam logic [5:0] OpLoad    = 6'h07;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StExec,
`ifdef PRPG_SEQ_RUNCNT_EN
        StRun,
`endif
        StLdw,
        StHalt,
        StErr
    } state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic [PC_W-1:0]     r_pc;
    logic [PC_W-1:0]     w_pc_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_addr_next;
    logic [13:0]         r_ir;
    logic [6:0]          r_tap;
    logic [7:0]          r_seed;
    logic [7:0]          r_ld_data;
    logic [5:0]          w_op;
    logic [7:0]          w_opd;
    logic [ADDR_W-1:0]   w_opd_addr;

    assign w_op       = r_ir[13:8];
    assign w_opd      = r_ir[7:0];
    assign w_opd_addr = ADDR_W'(w_opd);

`ifdef PRPG_SEQ_RUNCNT_EN
    logic [7:0] r_remaining;
    logic [7:0] w_remaining_next;
    logic [7:0] w_run_count;

    assign w_run_count = (w_opd == 8'd0) ? 8'd1 : w_opd;
`endif

    assign o_pc        = r_pc;
    assign o_tap       = r_tap;
    assign o_seed      = r_seed;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = i_lfsr_q;

    // Next-state, pc/address update and Moore strobes from registered state and IR.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_addr_next  = r_addr;
        o_tap_we     = 1'b0;
        o_seed_we    = 1'b0;
        o_step       = 1'b0;
        o_ld_we      = 1'b0;
        o_mem_we     = 1'b0;
        o_mem_re     = 1'b0;
        o_busy       = 1'b0;
        o_halted     = 1'b0;
        o_err        = 1'b0;
        // In LDW the engine latches the read data this cycle, so it is passed straight through.
        o_ld_data    = r_ld_data;
`ifdef PRPG_SEQ_RUNCNT_EN
        w_remaining_next = r_remaining;
`endif
        case (r_state)
            StIdle, StHalt, StErr: begin
                o_halted = (r_state == StHalt);
                o_err    = (r_state == StErr);
                if (i_start) begin
                    w_pc_next    = '0;
                    w_addr_next  = '0;
                    w_state_next = StFetch;
                end
            end
            StFetch: begin
                o_busy       = 1'b1;
                w_state_next = StExec;
            end
            StExec: begin
                o_busy       = 1'b1;
                w_pc_next    = r_pc + 1'b1;
                w_state_next = StFetch;
                case (w_op)
                    OpHalt: begin
                        w_pc_next    = r_pc;
                        w_state_next = StHalt;
                    end
                    OpConfig:  o_tap_we  = 1'b1;
                    OpSeed:    o_seed_we = 1'b1;
                    OpRun: begin
                        o_step = 1'b1;
`ifdef PRPG_SEQ_RUNCNT_EN
                        if (w_run_count > 8'd1) begin
                            w_remaining_next = w_run_count - 8'd1;
                            w_pc_next        = r_pc;
                            w_state_next     = StRun;
                        end
`endif
                    end
                    OpInitAdr: w_addr_next = w_opd_addr;
                    OpStore:   o_mem_we    = 1'b1;
                    OpAddAdr:  w_addr_next = r_addr + w_opd_addr;
                    OpLoad: begin
                        o_mem_re     = 1'b1;
                        w_pc_next    = r_pc;
                        w_state_next = StLdw;
                    end
                    default: begin
                        w_pc_next    = r_pc;
                        w_state_next = StErr;
                    end
                endcase
            end
`ifdef PRPG_SEQ_RUNCNT_EN
            StRun: begin
                o_busy           = 1'b1;
                o_step           = 1'b1;
                w_remaining_next = r_remaining - 8'd1;
                if (r_remaining == 8'd1) begin
                    w_pc_next    = r_pc + 1'b1;
                    w_state_next = StFetch;
                end
            end
`endif
            StLdw: begin
                o_busy       = 1'b1;
                o_ld_we      = 1'b1;
                o_ld_data    = i_mem_rdata;
                w_pc_next    = r_pc + 1'b1;
                w_state_next = StFetch;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // State, pc, address, IR and held engine operands.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= StIdle;
            r_pc      <= '0;
            r_addr    <= '0;
            r_ir      <= '0;
            r_tap     <= '0;
            r_seed    <= '0;
            r_ld_data <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_addr  <= w_addr_next;
            if (r_state == StFetch) begin
                r_ir <= i_instr;
                // Operands are captured at fetch so they are stable for the EXEC strobe.
                if (i_instr[13:8] == OpConfig) begin
                    r_tap <= i_instr[6:0];
                end
                if (i_instr[13:8] == OpSeed) begin
                    r_seed <= i_instr[7:0];
                end
            end
            if (r_state == StLdw) begin
                r_ld_data <= i_mem_rdata;
            end
        end
    end

`ifdef PRPG_SEQ_RUNCNT_EN
    // Remaining-step counter for multi-cycle run.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_remaining <= '0;
        end else begin
            r_remaining <= w_remaining_next;
        end
    end
`endif

endmodule
